sdcmd_tx: RTL and testbench



---
 rtl/sd_pkg.sv | 15 +
 rtl/sdcrc7_step.sv | 18 +
 rtl/sdcmd_tx.sv | 170 +++++++++++++++++
 tb/tb_sdcmd_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD-host definitions: command frame geometry, CRC7 polynomial and
// the command-transmitter state encoding.
package sd_pkg;

  localparam int SD_CMD_FRAME_BITS = 48;
  localparam int SD_CMD_DATA_BITS  = 40;
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    STOP = 2'd2
  } sdcmd_tx_state_t;

endpackage

// File: rtl/sdcrc7_step.sv
// Single-bit CRC7 update (x^7 + x^3 + 1); chained twice for two-bit steps.
module sdcrc7_step
  import sd_pkg::*;
(
  input  logic [6:0] crc_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic fb_s;

  // Feedback is the incoming bit against the CRC MSB
  always_comb begin
    fb_s  = crc_i[6] ^ bit_i;
    crc_o = {crc_i[5:0], 1'b0} ^ (fb_s ? SD_CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sdcmd_tx.sv
// SD CMD-line serializer: shifts out {start, dir, index, arg, CRC7, end}
// on SD-clock falling-edge strobes, one bit or (ckspd==0) two bits per step.
module sdcmd_tx
  import sd_pkg::*;
#(
  parameter int LGMAXDIV = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ckstb,
  input  logic                i_hlfck,
  input  logic [LGMAXDIV-1:0] i_ckspd,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [5:0]          i_cmd,
  input  logic [31:0]         i_arg,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cmd_en,
  output logic [1:0]          o_cmd_data
);

  localparam logic [5:0] DATA_BITS_C  = 6'(SD_CMD_DATA_BITS);
  localparam logic [5:0] FRAME_BITS_C = 6'(SD_CMD_FRAME_BITS);

  sdcmd_tx_state_t state_q, state_d;
  logic [39:0] sh_q, sh_d;
  logic [6:0]  crc_q, crc_d, crc_one_s, crc_two_s;
  logic [5:0]  cnt_q, cnt_d, step_s;
  logic        wide_q, wide_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cmd_en_q, cmd_en_d;
  logic [1:0]  cmd_data_q, cmd_data_d;
  logic        bit_hi_s, bit_lo_s;
  logic        ckstb_unused_s;

  assign ckstb_unused_s = i_ckstb;

  sdcrc7_step u_crc_hi (
    .crc_i (crc_q),
    .bit_i (sh_q[39]),
    .crc_o (crc_one_s)
  );

  sdcrc7_step u_crc_lo (
    .crc_i (crc_one_s),
    .bit_i (sh_q[38]),
    .crc_o (crc_two_s)
  );

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    wide_d     = wide_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmd_en_d   = cmd_en_q;
    cmd_data_d = cmd_data_q;
    bit_hi_s   = 1'b1;
    bit_lo_s   = 1'b1;
    step_s     = wide_q ? 6'd2 : 6'd1;

    case (state_q)
      IDLE: begin
        ready_d    = 1'b1;
        busy_d     = 1'b0;
        cmd_en_d   = 1'b0;
        cmd_data_d = 2'b11;
        if (i_valid && ready_q) begin
          sh_d    = {1'b0, 1'b1, i_cmd, i_arg};
          crc_d   = 7'h00;
          cnt_d   = 6'd0;
          wide_d  = (i_ckspd == {LGMAXDIV{1'b0}});
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (i_hlfck) begin
          if (cnt_q < DATA_BITS_C) begin
            bit_hi_s = sh_q[39];
            bit_lo_s = wide_q ? sh_q[38] : sh_q[39];
            sh_d     = wide_q ? {sh_q[37:0], 2'b00} : {sh_q[38:0], 1'b0};
            crc_d    = wide_q ? crc_two_s : crc_one_s;
          end else begin
            // Ones shifted in behind the CRC supply the end bit
            bit_hi_s = crc_q[6];
            bit_lo_s = wide_q ? crc_q[5] : crc_q[6];
            crc_d    = wide_q ? {crc_q[4:0], 2'b11} : {crc_q[5:0], 1'b1};
          end
          cmd_en_d   = 1'b1;
          cmd_data_d = {bit_hi_s, bit_lo_s};
          cnt_d      = cnt_q + step_s;
          if ((cnt_q + step_s) == FRAME_BITS_C) begin
            state_d = STOP;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end

      STOP: begin
        if (i_hlfck) begin
          cmd_en_d   = 1'b0;
          cmd_data_d = 2'b11;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d    = IDLE;
        ready_d    = 1'b1;
        busy_d     = 1'b0;
        cmd_en_d   = 1'b0;
        cmd_data_d = 2'b11;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      sh_q       <= 40'h0;
      crc_q      <= 7'h00;
      cnt_q      <= 6'd0;
      wide_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_en_q   <= 1'b0;
      cmd_data_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      wide_q     <= wide_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmd_en_q   <= cmd_en_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_cmd_en   = cmd_en_q;
  assign o_cmd_data = cmd_data_q;

endmodule

// File: tb/tb_sdcmd_tx.sv
// Self-checking bench for sdcmd_tx: table vectors, hand-written corner
// sequences and random commands against a polynomial-division frame model.
module tb_sdcmd_tx;

  logic        i_clk     = 1'b0;
  logic        i_reset_n;
  logic        i_ckstb   = 1'b0;
  logic        i_hlfck   = 1'b1;
  logic [7:0]  i_ckspd;
  logic        i_valid;
  logic [5:0]  i_cmd;
  logic [31:0] i_arg;
  logic        o_ready, o_busy, o_done, o_cmd_en;
  logic [1:0]  o_cmd_data;

  int   checks = 0;
  int   errors = 0;
  int   hmode  = 0;
  logic hl_prev = 1'b0;
  int   cyc = 0;
  int   div_cnt = 0;
  int   done_cyc, first_en_cyc;
  logic [1:0] first_data;

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  spd;
    int          hmode;
    logic [47:0] frame;
    int          en_cyc;
  } vec_t;

  sdcmd_tx #(.LGMAXDIV(8)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ckstb    (i_ckstb),
    .i_hlfck    (i_hlfck),
    .i_ckspd    (i_ckspd),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_cmd      (i_cmd),
    .i_arg      (i_arg),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_cmd_en   (o_cmd_en),
    .o_cmd_data (o_cmd_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Strobe generator: hmode 0 = always on, 1 = sparse random, 2 = every 4th
  initial begin
    forever begin
      @(posedge i_clk);
      hl_prev = i_hlfck;
      #1;
      div_cnt = (div_cnt + 1) % 4;
      case (hmode)
        0:       i_hlfck = 1'b1;
        1:       i_hlfck = ($urandom_range(0, 4) == 0);
        default: i_hlfck = (div_cnt == 0);
      endcase
      i_ckstb = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] m;
    m = {2'b01, c, a};
    return {m, ref_crc7(m), 1'b1};
  endfunction

  task automatic request(input logic [5:0] c, input logic [31:0] a, input logic [7:0] spd, input bit hold);
    int w;
    @(negedge i_clk);
    i_cmd = c; i_arg = a; i_ckspd = spd; i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    @(negedge i_clk);
    chk(o_busy && !o_ready, "accept", 64'({o_ready, o_busy}), 64'(2'b01));
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic capture(input logic [47:0] exp, input bit wide, input string nm, input int exp_en,
                         input bit chain, input logic [5:0] nc, input logic [31:0] na);
    logic [47:0] got;
    logic [3:0]  last;
    int nb, steps, en_cyc, stab_err, pair_err, cycles;
    bit done_seen, first_seen;
    got = '0; nb = 0; steps = 0; en_cyc = 0; stab_err = 0; pair_err = 0; cycles = 0;
    done_seen = 1'b0; first_seen = 1'b0;
    last = {o_done, o_cmd_en, o_cmd_data};
    while (!done_seen && cycles < 5000) begin
      @(negedge i_clk);
      cycles++;
      if (o_cmd_en) begin
        en_cyc++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_en_cyc = cyc;
          first_data = o_cmd_data;
        end
      end
      if (!hl_prev) begin
        if ({o_done, o_cmd_en, o_cmd_data} != last) stab_err++;
      end else if (o_cmd_en) begin
        steps++;
        if (wide) begin
          if (nb <= 46) begin
            got[47 - nb] = o_cmd_data[1];
            got[46 - nb] = o_cmd_data[0];
          end
          nb += 2;
        end else begin
          if (nb <= 47) got[47 - nb] = o_cmd_data[1];
          if (o_cmd_data[1] != o_cmd_data[0]) pair_err++;
          nb++;
        end
      end
      last = {o_done, o_cmd_en, o_cmd_data};
      i_cmd = 6'($urandom);
      i_arg = $urandom;
      if (o_done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        chk(!o_cmd_en && o_cmd_data == 2'b11 && o_ready && !o_busy, {nm, "_done_state"},
            64'({o_cmd_en, o_cmd_data, o_ready, o_busy}), 64'(5'b0_11_1_0));
        if (chain) begin
          i_cmd = nc;
          i_arg = na;
        end
      end
    end
    chk(done_seen, {nm, "_timeout"}, 64'(cycles), 64'(5000));
    chk(got == exp, {nm, "_frame"}, 64'(got), 64'(exp));
    chk(steps == (wide ? 24 : 48), {nm, "_steps"}, 64'(steps), 64'(wide ? 24 : 48));
    chk(pair_err == 0, {nm, "_pair"}, 64'(pair_err), 64'(0));
    chk(stab_err == 0, {nm, "_stable"}, 64'(stab_err), 64'(0));
    if (exp_en >= 0) chk(en_cyc == exp_en, {nm, "_en_cycles"}, 64'(en_cyc), 64'(exp_en));
    if (!chain) begin
      @(negedge i_clk);
      chk(!o_done && o_ready, {nm, "_done_pulse"}, 64'({o_done, o_ready}), 64'(2'b01));
    end
  endtask

  initial begin
    vec_t tbl[3];
    logic [5:0]  c1, c2;
    logic [31:0] a1, a2;
    logic [7:0]  spd;
    int d1, n, w;

    tbl[0] = '{cmd: 6'd0,  arg: 32'h0000_0000, spd: 8'd4, hmode: 2, frame: 48'h40_0000_0000_95, en_cyc: -1};
    tbl[1] = '{cmd: 6'd8,  arg: 32'h0000_01AA, spd: 8'd1, hmode: 0, frame: 48'h48_0000_01AA_87, en_cyc: 48};
    tbl[2] = '{cmd: 6'd55, arg: 32'h0000_0000, spd: 8'd0, hmode: 0, frame: 48'h77_0000_0000_65, en_cyc: 24};

    i_reset_n = 1'b0; i_valid = 1'b0; i_cmd = 6'd0; i_arg = 32'd0; i_ckspd = 8'd4;
    repeat (3) @(negedge i_clk);
    chk(o_ready == 1'b1, "rst_ready", 64'(o_ready), 64'(1));
    chk(o_busy == 1'b0, "rst_busy", 64'(o_busy), 64'(0));
    chk(o_done == 1'b0, "rst_done", 64'(o_done), 64'(0));
    chk(o_cmd_en == 1'b0, "rst_cmd_en", 64'(o_cmd_en), 64'(0));
    chk(o_cmd_data == 2'b11, "rst_cmd_data", 64'(o_cmd_data), 64'(2'b11));
    i_reset_n = 1'b1;
    @(negedge i_clk);

    foreach (tbl[k]) begin
      hmode = tbl[k].hmode;
      request(tbl[k].cmd, tbl[k].arg, tbl[k].spd, 1'b0);
      capture(tbl[k].frame, tbl[k].spd == 8'd0, $sformatf("vec%0d", k), tbl[k].en_cyc, 1'b0, 6'd0, 32'd0);
      if (tbl[k].spd == 8'd0) chk(first_data == 2'b01, "wide_first_pair", 64'(first_data), 64'(2'b01));
    end

    // Back-to-back with i_valid held throughout
    hmode = 0;
    c1 = 6'd2; a1 = $urandom; c2 = 6'd55; a2 = $urandom;
    request(c1, a1, 8'd1, 1'b1);
    capture(ref_frame(c1, a1), 1'b0, "b2b_first", 48, 1'b1, c2, a2);
    d1 = done_cyc;
    @(negedge i_clk);
    chk(o_busy && !o_ready && !o_done, "b2b_accept", 64'({o_busy, o_ready, o_done}), 64'(3'b100));
    i_valid = 1'b0;
    capture(ref_frame(c2, a2), 1'b0, "b2b_second", 48, 1'b0, 6'd0, 32'd0);
    chk(first_en_cyc - d1 == 2, "b2b_gap", 64'(first_en_cyc - d1), 64'(2));

    // Sparse strobes at a slow clock-speed code
    hmode = 1;
    c1 = 6'd17; a1 = $urandom;
    request(c1, a1, 8'd250, 1'b0);
    capture(ref_frame(c1, a1), 1'b0, "sparse", -1, 1'b0, 6'd0, 32'd0);

    // Reset in the middle of a frame, then a clean frame
    hmode = 0;
    request(6'd24, 32'hDEAD_BEEF, 8'd1, 1'b0);
    n = 0; w = 0;
    while (n < 20 && w < 200) begin
      @(negedge i_clk);
      w++;
      if (o_cmd_en) n++;
    end
    chk(n == 20, "midrst_reach", 64'(n), 64'(20));
    #2 i_reset_n = 1'b0;
    #1;
    chk(!o_cmd_en && o_cmd_data == 2'b11 && o_ready && !o_busy && !o_done, "midrst_outputs",
        64'({o_cmd_en, o_cmd_data, o_ready, o_busy, o_done}), 64'(6'b0_11_1_0_0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    c1 = 6'd41; a1 = $urandom;
    request(c1, a1, 8'd1, 1'b0);
    capture(ref_frame(c1, a1), 1'b0, "post_rst", 48, 1'b0, 6'd0, 32'd0);

    // Random commands at random speeds
    for (int r = 0; r < 8; r++) begin
      c1 = 6'($urandom);
      a1 = $urandom;
      case ($urandom_range(0, 3))
        0:       spd = 8'd0;
        1:       spd = 8'd1;
        default: spd = 8'($urandom_range(2, 255));
      endcase
      hmode = (spd <= 8'd1) ? 0 : 1;
      request(c1, a1, spd, 1'b0);
      capture(ref_frame(c1, a1), spd == 8'd0, $sformatf("rand%0d", r),
              (spd == 8'd0) ? 24 : ((spd == 8'd1) ? 48 : -1), 1'b0, 6'd0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
